// File: rtl/fifo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_pkg : default FIFO geometry, flag margins and pointer-width helper.
// Rev 1.0
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_DATA_W    = 8;
  localparam int FIFO_DEPTH     = 8;
  localparam int FIFO_AF_MARGIN = 2;
  localparam int FIFO_AE_MARGIN = 2;

  // One extra bit beyond the address distinguishes full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_mem : DEPTH x DATA_W register array, synchronous write, registered read.
// Rev 1.0
// ---------------------------------------------------------------------------
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int AW     = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/async_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// async_fifo : single-clock circular FIFO with count-derived status flags.
// Optional overflow/underflow pulses when FIFO_ERR_FLAGS_EN is defined.
// Rev 1.0
// ---------------------------------------------------------------------------
module async_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int AF_MARGIN = FIFO_AF_MARGIN,
  parameter int AE_MARGIN = FIFO_AE_MARGIN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
  output logic              overflow,
  output logic              underflow,
`endif
  output logic              half
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] count;
  logic          wr_ok;
  logic          rd_ok;

  assign count = wptr - rptr;

  assign full         = (count == PW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= PW'(DEPTH - AF_MARGIN));
  assign almost_empty = (count <= PW'(AE_MARGIN));
  assign half         = (count >= PW'(DEPTH / 2));

  // Both requests are qualified by the pre-edge flags; no write-through.
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wptr[AW-1:0]),
    .wdata (wr_data),
    .re    (rd_ok),
    .raddr (rptr[AW-1:0]),
    .rdata (rd_data)
  );

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_async_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_async_fifo : directed self-checking bench for async_fifo.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_async_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data;
  logic       full, empty, almost_full, almost_empty, half;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  async_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .wr_data      (wr_data),
    .rd_data      (rd_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .half         (half)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst   = 1'b0;
    #25;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({empty, almost_empty, full, almost_full, half} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_flags: got e/ae/f/af/h=%b expected 11000",
               {empty, almost_empty, full, almost_full, half});
    end
    vectors++;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rd_data: got %h expected 00", rd_data);
    end
  endtask

  task automatic test_fill();
    logic [7:0] exp_data;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i * 8'h11);
      tick();
      vectors++;
      if ({half, almost_full, full} !== {(i >= 4), (i >= 6), (i == 8)}) begin
        errors++;
        $display("FAIL fill_flags[%0d]: got h/af/f=%b expected %b", i,
                 {half, almost_full, full}, {(i >= 4), (i >= 6), (i == 8)});
      end
    end
    wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    vectors++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL drop_full: got full=%b expected 1", full);
    end
`ifdef FIFO_ERR_FLAGS_EN
    vectors++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_pulse: got %b expected 1", overflow);
    end
`endif
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1;
      tick();
      exp_data = 8'(i * 8'h11);
      vectors++;
      if (rd_data !== exp_data) begin
        errors++;
        $display("FAIL fill_read[%0d]: got %h expected %h", i, rd_data, exp_data);
      end
    end
    rd_en = 1'b0;
    vectors++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL fill_drained_empty: got %b expected 1", empty);
    end
  endtask

  task automatic test_almost_empty();
    do_reset();
    wr_en   = 1'b1;
    wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    vectors++;
    if ({empty, almost_empty, half} !== 3'b010) begin
      errors++;
      $display("FAIL ae_one_entry: got e/ae/h=%b expected 010", {empty, almost_empty, half});
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    vectors++;
    if (rd_data !== 8'h5A) begin
      errors++;
      $display("FAIL ae_read: got %h expected 5a", rd_data);
    end
    vectors++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL ae_empty_after: got %b expected 1", empty);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    vectors++;
    if ({empty, almost_empty, rd_data} !== {2'b11, 8'h00}) begin
      errors++;
      $display("FAIL underflow_hold: got e=%b ae=%b rd=%h expected e=1 ae=1 rd=00",
               empty, almost_empty, rd_data);
    end
`ifdef FIFO_ERR_FLAGS_EN
    vectors++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow_pulse: got %b expected 1", underflow);
    end
    tick();
    vectors++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clear: got %b expected 0", underflow);
    end
`endif
    // Pointers must not have moved: one write then one read drains exactly.
    wr_en   = 1'b1;
    wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    vectors++;
    if ({rd_data, empty} !== {8'h3C, 1'b1}) begin
      errors++;
      $display("FAIL underflow_ptrs: got rd=%h e=%b expected rd=3c e=1", rd_data, empty);
    end
  endtask

  task automatic test_circular();
    logic [7:0] exp_data;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h01 + i);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd_en = 1'b1;
      tick();
      exp_data = 8'(8'h01 + i);
      vectors++;
      if (rd_data !== exp_data) begin
        errors++;
        $display("FAIL circ_pre[%0d]: got %h expected %h", i, rd_data, exp_data);
      end
    end
    rd_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'hBC + i);
      tick();
    end
    wr_en = 1'b0;
    vectors++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL circ_full: got %b expected 1", full);
    end
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      tick();
      exp_data = 8'(8'hBC + i);
      vectors++;
      if (rd_data !== exp_data) begin
        errors++;
        $display("FAIL circ_read[%0d]: got %h expected %h", i, rd_data, exp_data);
      end
    end
    rd_en = 1'b0;
    vectors++;
    if ({rd_data, empty} !== {8'hC3, 1'b1}) begin
      errors++;
      $display("FAIL circ_last: got rd=%h e=%b expected rd=c3 e=1", rd_data, empty);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'hD1 + i);
      tick();
    end
    wr_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({empty, half, rd_data} !== {1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL mid_reset_async: got e=%b h=%b rd=%h expected e=1 h=0 rd=00",
               empty, half, rd_data);
    end
    #22;
    @(negedge clk);
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    vectors++;
    if ({rd_data, empty} !== {8'hA5, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset_read: got rd=%h e=%b expected rd=a5 e=1", rd_data, empty);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr_en   = 1'b1;
    wr_data = 8'h10;
    tick();
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      wr_data = 8'(8'h20 + 8'(i * 8'h10));
      tick();
      vectors++;
      if ({rd_data, empty} !== {8'(8'h10 + 8'(i * 8'h10)), 1'b0}) begin
        errors++;
        $display("FAIL b2b[%0d]: got rd=%h e=%b expected rd=%h e=0", i, rd_data, empty,
                 8'(8'h10 + 8'(i * 8'h10)));
      end
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_almost_empty();
    test_underflow();
    test_circular();
    test_reset_midstream();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
